// File: rtl/instr_fetch_decode_pkg.sv
// Shared definitions for the fetch/decode front end: FSM states, opcode and
// funct constants, command codes, next-PC source codes and the decoded-field
// bundle that the top registers in S_DEC.
package instr_fetch_decode_pkg;

    typedef enum logic [2:0] {
        S_REQ   = 3'd0,
        S_WAIT  = 3'd1,
        S_DEC   = 3'd2,
        S_ISSUE = 3'd3,
        S_EXEC  = 3'd4
    } ifd_state_e;

    // Primary opcodes ir[31:26]
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type funct codes ir[5:0]
    localparam logic [5:0] FN_JR  = 6'h08;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_SLT = 6'h2A;

    // Command codes handed to the control FSM
    localparam logic [3:0] CMD_NOP  = 4'd0;
    localparam logic [3:0] CMD_LW   = 4'd1;
    localparam logic [3:0] CMD_SW   = 4'd2;
    localparam logic [3:0] CMD_J    = 4'd3;
    localparam logic [3:0] CMD_JAL  = 4'd4;
    localparam logic [3:0] CMD_BNE  = 4'd5;
    localparam logic [3:0] CMD_XORI = 4'd6;
    localparam logic [3:0] CMD_ADDI = 4'd7;
    localparam logic [3:0] CMD_ADD  = 4'd8;
    localparam logic [3:0] CMD_SUB  = 4'd9;
    localparam logic [3:0] CMD_SLT  = 4'd10;
    localparam logic [3:0] CMD_JR   = 4'd11;

    // Next-PC source selector presented with instr_done
    localparam logic [1:0] PC_SRC_SEQ    = 2'b00;
    localparam logic [1:0] PC_SRC_BRANCH = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;
    localparam logic [1:0] PC_SRC_JR     = 2'b11;

    typedef struct packed {
        logic [3:0]  cmd;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [31:0] imm;
    } dec_fields_t;

    function automatic logic [31:0] sext16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

endpackage

// File: rtl/instr_decode.sv
// Purely combinational instruction decoder: ir -> command, register fields,
// extended immediate and an "unknown encoding" flag. The caller decides what
// to do with unknown encodings; here they simply map to CMD_NOP.
module instr_decode
    import instr_fetch_decode_pkg::*;
(
    input  logic [31:0] ir,
    output logic [3:0]  cmd,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [31:0] imm,
    output logic        is_illegal
);

    logic [5:0] opcode;
    logic [5:0] funct;

    assign opcode = ir[31:26];
    assign funct  = ir[5:0];
    assign rs     = ir[25:21];
    assign rt     = ir[20:16];
    assign rd     = ir[15:11];

    // Opcode/funct lookup; XORI is the only zero-extended immediate
    always_comb begin
        cmd        = CMD_NOP;
        imm        = sext16(ir[15:0]);
        is_illegal = 1'b0;
        case (opcode)
            OP_LW:   cmd = CMD_LW;
            OP_SW:   cmd = CMD_SW;
            OP_J:    cmd = CMD_J;
            OP_JAL:  cmd = CMD_JAL;
            OP_BNE:  cmd = CMD_BNE;
            OP_ADDI: cmd = CMD_ADDI;
            OP_XORI: begin
                cmd = CMD_XORI;
                imm = {16'h0000, ir[15:0]};
            end
            OP_RTYPE: begin
                case (funct)
                    FN_ADD:  cmd = CMD_ADD;
                    FN_SUB:  cmd = CMD_SUB;
                    FN_SLT:  cmd = CMD_SLT;
                    FN_JR:   cmd = CMD_JR;
                    default: is_illegal = 1'b1;
                endcase
            end
            default: is_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/instr_fetch_decode.sv
// Fetch/decode front end for the multicycle core. Owns the PC, issues one
// fetch per instruction, latches and decodes the returned word and offers it
// to the control FSM over dec_valid/dec_ready. The PC moves only when the FSM
// retires the instruction with instr_done and a pc_src selection.
// Build option: define IFD_ILLEGAL_TRAP_EN to redirect unknown encodings to
// TRAP_PC with a one-cycle illegal pulse instead of issuing them as CMD_NOP.
module instr_fetch_decode
    import instr_fetch_decode_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] TRAP_PC  = 32'h0000_0080
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_valid,
    input  logic [31:0] imem_data,
    output logic        dec_valid,
    input  logic        dec_ready,
    output logic [3:0]  cmd,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [31:0] imm,
    output logic [31:0] pc_plus4,
    input  logic        instr_done,
    input  logic [1:0]  pc_src,
    input  logic [31:0] jr_addr,
    output logic        illegal
);

    ifd_state_e  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;
    dec_fields_t fields_q, fields_d;
    logic        drop_q, drop_d;

    logic [3:0]  dec_cmd;
    logic [4:0]  dec_rs, dec_rt, dec_rd;
    logic [31:0] dec_imm;
    logic        dec_illegal;

    logic        fetch_accept;
    logic        trap_take;
    logic [31:0] seq_pc;
    logic [31:0] br_offset;
    logic [31:0] branch_target;
    logic [31:0] jump_target;
    logic [31:0] jr_target;

    instr_decode u_decode (
        .ir         (ir_q),
        .cmd        (dec_cmd),
        .rs         (dec_rs),
        .rt         (dec_rt),
        .rd         (dec_rd),
        .imm        (dec_imm),
        .is_illegal (dec_illegal)
    );

    // A response is taken only while waiting and not flagged as stale
    assign fetch_accept = (state_q == S_WAIT) && imem_valid && !drop_q;

`ifdef IFD_ILLEGAL_TRAP_EN
    assign trap_take = (state_q == S_DEC) && dec_illegal;
`else
    // Unknown encodings flow through as CMD_NOP; the decoder flag is not needed
    logic unused_illegal_flag;
    assign unused_illegal_flag = dec_illegal;
    assign trap_take           = 1'b0;
`endif

    assign seq_pc        = pc_q + 32'd4;
    assign br_offset     = sext16(ir_q[15:0]) << 2;
    assign branch_target = seq_pc + br_offset;
    assign jump_target   = {seq_pc[31:28], ir_q[25:0], 2'b00};
    assign jr_target     = jr_addr & 32'hFFFF_FFFC;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_REQ;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic for the fetch/decode/issue/execute loop
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_REQ:   state_d = S_WAIT;
            S_WAIT:  if (fetch_accept) state_d = S_DEC;
            S_DEC:   state_d = trap_take ? S_REQ : S_ISSUE;
            S_ISSUE: if (dec_ready) state_d = S_EXEC;
            S_EXEC:  if (instr_done) state_d = S_REQ;
            default: state_d = S_REQ;
        endcase
    end

    // FSM outputs; reset masks the combinational strobes
    always_comb begin
        imem_req  = (state_q == S_REQ) && !reset;
        dec_valid = (state_q == S_ISSUE);
        illegal   = trap_take && !reset;
    end

    // Datapath next values: PC, instruction register, decoded fields, drop flag
    always_comb begin
        pc_d     = pc_q;
        ir_d     = ir_q;
        fields_d = fields_q;
        drop_d   = drop_q;
        // Any response strobe consumes a pending stale-response marker
        if (imem_valid) begin
            drop_d = 1'b0;
        end
        if (fetch_accept) begin
            ir_d = imem_data;
        end
        if (state_q == S_DEC) begin
            fields_d = {dec_cmd, dec_rs, dec_rt, dec_rd, dec_imm};
        end
        if (trap_take) begin
            pc_d = TRAP_PC;
        end
        // instr_done counts only once the FSM has accepted the instruction
        if ((state_q == S_EXEC) && instr_done) begin
            case (pc_src)
                PC_SRC_SEQ:    pc_d = seq_pc;
                PC_SRC_BRANCH: pc_d = branch_target;
                PC_SRC_JUMP:   pc_d = jump_target;
                PC_SRC_JR:     pc_d = jr_target;
                default:       pc_d = seq_pc;
            endcase
        end
    end

    // Datapath registers; a reset during S_WAIT leaves a marker so the
    // in-flight response of the aborted fetch is thrown away
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q     <= RESET_PC;
            ir_q     <= 32'h0000_0000;
            fields_q <= {CMD_NOP, 15'd0, 32'h0000_0000};
            drop_q   <= (state_q == S_WAIT) || drop_d;
        end else begin
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            fields_q <= fields_d;
            drop_q   <= drop_d;
        end
    end

    assign imem_addr = pc_q;
    assign pc_plus4  = seq_pc;
    assign cmd       = fields_q.cmd;
    assign rs        = fields_q.rs;
    assign rt        = fields_q.rt;
    assign rd        = fields_q.rd;
    assign imm       = fields_q.imm;

endmodule

// File: tb/tb_instr_fetch_decode.sv
// Scoreboard bench for instr_fetch_decode: a driver plays instruction memory
// and the control FSM, pushing expected fetch addresses, decodes and illegal
// pulses into queues; a negedge monitor pops and compares whenever the DUT
// presents imem_req, dec_valid or illegal.
`timescale 1ns/1ps
module tb_instr_fetch_decode;
    import instr_fetch_decode_pkg::*;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] TRAP_PC  = 32'h0000_0080;
`ifdef IFD_ILLEGAL_TRAP_EN
    localparam bit TRAP_MODE = 1'b1;
`else
    localparam bit TRAP_MODE = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_valid;
    logic [31:0] imem_data;
    logic        dec_valid;
    logic        dec_ready;
    logic [3:0]  cmd;
    logic [4:0]  rs, rt, rd;
    logic [31:0] imm;
    logic [31:0] pc_plus4;
    logic        instr_done;
    logic [1:0]  pc_src;
    logic [31:0] jr_addr;
    logic        illegal;

    instr_fetch_decode #(
        .RESET_PC (RESET_PC),
        .TRAP_PC  (TRAP_PC)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_valid (imem_valid),
        .imem_data  (imem_data),
        .dec_valid  (dec_valid),
        .dec_ready  (dec_ready),
        .cmd        (cmd),
        .rs         (rs),
        .rt         (rt),
        .rd         (rd),
        .imm        (imm),
        .pc_plus4   (pc_plus4),
        .instr_done (instr_done),
        .pc_src     (pc_src),
        .jr_addr    (jr_addr),
        .illegal    (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  cmd;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic [31:0] pc4;
    } exp_t;

    exp_t        exp_dec_q[$];
    logic [31:0] exp_addr_q[$];
    int          exp_ill_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] model_pc;

    // Reference tables: opcode -> command and R-type funct -> command
    logic [3:0] op_tab [logic [5:0]];
    logic [3:0] fn_tab [logic [5:0]];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
        end
    endtask

    function automatic bit ref_is_illegal(input logic [31:0] w);
        if (w[31:26] == 6'h00) return !fn_tab.exists(w[5:0]);
        return !op_tab.exists(w[31:26]);
    endfunction

    function automatic exp_t ref_decode(input logic [31:0] w, input logic [31:0] pc);
        exp_t e;
        e.rs  = w[25:21];
        e.rt  = w[20:16];
        e.rd  = w[15:11];
        e.pc4 = pc + 32'd4;
        e.cmd = CMD_NOP;
        if (w[31:26] == 6'h00) begin
            if (fn_tab.exists(w[5:0])) e.cmd = fn_tab[w[5:0]];
        end else if (op_tab.exists(w[31:26])) begin
            e.cmd = op_tab[w[31:26]];
        end
        if (w[31:26] == 6'h0E) e.imm = {16'h0000, w[15:0]};
        else                   e.imm = {{16{w[15]}}, w[15:0]};
        return e;
    endfunction

    function automatic logic [31:0] ref_next_pc(input logic [31:0] pc, input logic [31:0] w,
                                                input logic [31:0] jr, input logic [1:0] src);
        logic [31:0] seq;
        logic [31:0] off;
        seq = pc + 32'd4;
        off = {{16{w[15]}}, w[15:0]} * 32'd4;
        case (src)
            2'd0:    return seq;
            2'd1:    return seq + off;
            2'd2:    return (seq & 32'hF000_0000) | ({6'd0, w[25:0]} * 32'd4);
            default: return jr & ~32'd3;
        endcase
    endfunction

    // Record what the DUT must show once this word has been accepted
    task automatic push_expect(input logic [31:0] w);
        if (TRAP_MODE && ref_is_illegal(w)) begin
            exp_ill_q.push_back(1);
            model_pc = TRAP_PC;
        end else begin
            exp_dec_q.push_back(ref_decode(w, model_pc));
        end
    endtask

    // Return the word after 'delay' cycles, optionally with a stray instr_done
    task automatic respond(input logic [31:0] w, input int delay, input bit stray);
        for (int i = 0; i < delay; i++) begin
            @(posedge clk); #1;
            instr_done = stray && (i == 0);
            pc_src     = 2'b10;
        end
        instr_done = 1'b0;
        imem_valid = 1'b1;
        imem_data  = w;
        @(posedge clk); #1;
        imem_valid = 1'b0;
        imem_data  = $urandom;
        push_expect(w);
    endtask

    task automatic wait_req();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (imem_req) begin
                ok = 1'b1;
                break;
            end
        end
        chk("req_seen", {31'd0, ok}, 32'd1);
    endtask

    // Accept the decode (after 'hold' cycles) and retire it with src/jr
    task automatic retire(input logic [31:0] w, input int hold, input bit overlap,
                          input logic [1:0] src, input logic [31:0] jr);
        bit ok;
        int gap;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (dec_valid) begin
                ok = 1'b1;
                break;
            end
        end
        chk("dec_valid_seen", {31'd0, ok}, 32'd1);
        if (!ok) return;
        @(posedge clk); #1;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
        end
        dec_ready = 1'b1;
        if (overlap) begin
            instr_done = 1'b1;
            pc_src     = ~src;
            jr_addr    = $urandom;
        end
        @(posedge clk); #1;
        dec_ready  = 1'b0;
        instr_done = 1'b0;
        @(negedge clk);
        chk("dec_valid_drop", {31'd0, dec_valid}, 32'd0);
        gap = $urandom_range(0, 3);
        for (int i = 0; i < gap; i++) begin
            @(posedge clk); #1;
            dec_ready  = $urandom_range(0, 1);
            imem_valid = ($urandom_range(0, 3) == 0);
            imem_data  = $urandom;
        end
        @(posedge clk); #1;
        imem_valid = 1'b0;
        dec_ready  = 1'b0;
        instr_done = 1'b1;
        pc_src     = src;
        jr_addr    = jr;
        @(posedge clk); #1;
        instr_done = 1'b0;
        model_pc   = ref_next_pc(model_pc, w, jr, src);
    endtask

    task automatic run_instr(input logic [31:0] w, input int delay, input int hold,
                             input bit overlap, input bit stray,
                             input logic [1:0] src, input logic [31:0] jr);
        exp_addr_q.push_back(model_pc);
        wait_req();
        respond(w, delay, stray);
        if (!(TRAP_MODE && ref_is_illegal(w))) retire(w, hold, overlap, src, jr);
    endtask

    // Reset while waiting for a response; the stale response arrives 'gap' cycles later
    task automatic reset_in_wait(input int gap, input logic [31:0] w);
        exp_addr_q.push_back(model_pc);
        wait_req();
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset    = 1'b0;
        model_pc = RESET_PC;
        exp_addr_q.push_back(RESET_PC);
        for (int i = 0; i < gap; i++) begin
            @(posedge clk); #1;
        end
        imem_valid = 1'b1;
        imem_data  = 32'h8C22_0004;
        @(posedge clk); #1;
        imem_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("no_issue_after_drop", {31'd0, dec_valid}, 32'd0);
        end
        respond(w, 1, 1'b0);
        retire(w, 0, 1'b0, 2'b00, 32'd0);
    endtask

    function automatic logic [31:0] gen_instr();
        logic [5:0]  i_ops [7];
        logic [5:0]  r_fns [4];
        logic [5:0]  bad_ops [4];
        logic [5:0]  bad_fns [3];
        logic [31:0] w;
        int          kind;
        i_ops   = '{6'h23, 6'h2B, 6'h02, 6'h03, 6'h05, 6'h0E, 6'h08};
        r_fns   = '{6'h20, 6'h22, 6'h2A, 6'h08};
        bad_ops = '{6'h01, 6'h04, 6'h3F, 6'h10};
        bad_fns = '{6'h00, 6'h3F, 6'h21};
        w    = $urandom;
        kind = $urandom_range(0, 12);
        if (kind <= 6) begin
            w[31:26] = i_ops[kind];
        end else if (kind <= 10) begin
            w[31:26] = 6'h00;
            w[5:0]   = r_fns[kind - 7];
        end else if (kind == 11) begin
            w[31:26] = bad_ops[$urandom_range(0, 3)];
        end else begin
            w[31:26] = 6'h00;
            w[5:0]   = bad_fns[$urandom_range(0, 2)];
        end
        return w;
    endfunction

    // Scoreboard monitor: compares on every presented request, decode or pulse
    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            if (imem_req) begin
                if (exp_addr_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_req actual=%h required=none t=%0t", imem_addr, $time);
                end else begin
                    chk("imem_addr", imem_addr, exp_addr_q.pop_front());
                end
            end
            if (dec_valid) begin
                if (exp_dec_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_dec_valid actual=cmd %h required=none t=%0t", cmd, $time);
                end else begin
                    e = exp_dec_q[0];
                    chk("cmd", {28'd0, cmd}, {28'd0, e.cmd});
                    chk("rs", {27'd0, rs}, {27'd0, e.rs});
                    chk("rt", {27'd0, rt}, {27'd0, e.rt});
                    chk("rd", {27'd0, rd}, {27'd0, e.rd});
                    chk("imm", imm, e.imm);
                    chk("pc_plus4", pc_plus4, e.pc4);
                    if (dec_ready) void'(exp_dec_q.pop_front());
                end
            end
            if (illegal) begin
                checks++;
                if (exp_ill_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_illegal actual=1 required=0 t=%0t", $time);
                end else begin
                    void'(exp_ill_q.pop_front());
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        op_tab[6'h23] = CMD_LW;   op_tab[6'h2B] = CMD_SW;
        op_tab[6'h02] = CMD_J;    op_tab[6'h03] = CMD_JAL;
        op_tab[6'h05] = CMD_BNE;  op_tab[6'h0E] = CMD_XORI;
        op_tab[6'h08] = CMD_ADDI;
        fn_tab[6'h20] = CMD_ADD;  fn_tab[6'h22] = CMD_SUB;
        fn_tab[6'h2A] = CMD_SLT;  fn_tab[6'h08] = CMD_JR;

        reset      = 1'b1;
        imem_valid = 1'b0;
        imem_data  = 32'd0;
        dec_ready  = 1'b0;
        instr_done = 1'b0;
        pc_src     = 2'b00;
        jr_addr    = 32'd0;
        model_pc   = RESET_PC;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_imem_req", {31'd0, imem_req}, 32'd0);
        chk("rst_imem_addr", imem_addr, RESET_PC);
        chk("rst_dec_valid", {31'd0, dec_valid}, 32'd0);
        chk("rst_cmd", {28'd0, cmd}, {28'd0, CMD_NOP});
        chk("rst_fields", {17'd0, rs, rt, rd}, 32'd0);
        chk("rst_imm", imm, 32'd0);
        chk("rst_illegal", {31'd0, illegal}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Directed sequence
        run_instr(32'h8C22_0004, 3, 0, 1'b0, 1'b0, 2'b00, 32'd0);          // LW at 0
        run_instr(32'h2064_FFFC, 1, 1, 1'b0, 1'b0, 2'b00, 32'd0);          // ADDI -4
        run_instr(32'h38A6_FFFC, 2, 0, 1'b0, 1'b1, 2'b11, 32'h0000_0100);  // XORI, jr to 0x100
        run_instr(32'h1422_FFFF, 1, 0, 1'b0, 1'b0, 2'b01, 32'd0);          // BNE taken -> 0x100
        run_instr(32'h1422_FFFF, 1, 2, 1'b0, 1'b0, 2'b00, 32'd0);          // BNE not taken -> 0x104
        run_instr(32'h03E0_0008, 1, 0, 1'b0, 1'b0, 2'b11, 32'h1000_0000);  // JR -> 0x1000_0000
        run_instr(32'h0FFF_FFFF, 2, 0, 1'b0, 1'b0, 2'b10, 32'd0);          // JAL -> 0x1FFF_FFFC
        run_instr(32'h03E0_0008, 1, 0, 1'b0, 1'b0, 2'b11, 32'h0000_0207);  // JR -> 0x204
        run_instr(32'h0043_2020, 1, 0, 1'b1, 1'b0, 2'b00, 32'd0);          // ADD, ready+done overlap
        run_instr(32'hFC00_0000, 1, 0, 1'b0, 1'b0, 2'b00, 32'd0);          // unknown opcode
        reset_in_wait(0, 32'h2064_0010);
        reset_in_wait(1, 32'h38A6_8001);

        // Randomized traffic
        for (int n = 0; n < 60; n++) begin
            run_instr(gen_instr(), $urandom_range(1, 4), $urandom_range(0, 2),
                      ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                      2'($urandom_range(0, 3)), $urandom);
        end

        exp_addr_q.push_back(model_pc);
        repeat (3) @(negedge clk);
        chk("addr_q_drained", exp_addr_q.size(), 32'd0);
        chk("dec_q_drained", exp_dec_q.size(), 32'd0);
        chk("ill_q_drained", exp_ill_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
